// File: rtl/memory_access.sv
// MEM pipeline stage: issues one data-bus transaction per load/store, extracts and
// extends load data, builds store strobes, and passes non-memory results through.
module memory_access #(
  parameter int XLEN           = 64,
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [4:0]      in_rd,
  input  logic            in_rd_we,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic            dreq_write,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_wdata,
  output logic            out_exc
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = |lo[1:0];
      default: misaligned = |lo;
    endcase
  endfunction

  function automatic logic [7:0] store_strobe(input logic [1:0] size, input logic [2:0] lo);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lo;
  endfunction

  function automatic logic [63:0] load_extract(input logic [2:0] f3, input logic [2:0] lo,
                                               input logic [63:0] data);
    logic [63:0] v;
    v = data >> {lo, 3'b000};
    case (f3)
      3'b000:  return {{56{v[7]}}, v[7:0]};
      3'b001:  return {{48{v[15]}}, v[15:0]};
      3'b010:  return {{32{v[31]}}, v[31:0]};
      3'b011:  return v;
      3'b100:  return {56'd0, v[7:0]};
      3'b101:  return {48'd0, v[15:0]};
      3'b110:  return {32'd0, v[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic              dreq_valid_q, dreq_valid_d, dreq_write_q, dreq_write_d;
  logic [XLEN-1:0]   dreq_addr_q, dreq_addr_d, dreq_data_q, dreq_data_d;
  logic [7:0]        dreq_strobe_q, dreq_strobe_d;
  logic [XLEN-1:0]   op_pc_q, op_pc_d;
  logic [31:0]       op_inst_q, op_inst_d;
  logic [4:0]        op_rd_q, op_rd_d;
  logic              op_rd_we_q, op_rd_we_d, op_is_load_q, op_is_load_d;
  logic [2:0]        op_funct3_q, op_funct3_d;
  logic              out_valid_q, out_valid_d, out_rd_we_q, out_rd_we_d, out_exc_q, out_exc_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d, out_wdata_q, out_wdata_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [4:0]        out_rd_q, out_rd_d;

  logic accept_s, is_mem_s, bad_f3_s, exc_s, issue_s, direct_s, done_s;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_s = in_valid && in_ready;
  assign is_mem_s = in_is_load || in_is_store;
  // A load wins when both load and store flags are set.
  assign bad_f3_s = in_is_load ? (in_funct3 == 3'b111) : in_funct3[2];
  assign exc_s    = is_mem_s && (bad_f3_s ||
                    (MISALIGN_CHECK && misaligned(in_funct3[1:0], in_alu_result[2:0])));
  assign issue_s  = accept_s && is_mem_s && !exc_s;
  assign direct_s = accept_s && !issue_s;
  assign done_s   = (state_q == BUSY) && dresp_ok;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = issue_s ? BUSY : IDLE;
      BUSY:    state_d = dresp_ok ? IDLE : BUSY;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the bus request, latched op and output registers
  always_comb begin
    dreq_valid_d  = dreq_valid_q;
    dreq_addr_d   = dreq_addr_q;
    dreq_write_d  = dreq_write_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_data_d   = dreq_data_q;
    op_pc_d       = op_pc_q;
    op_inst_d     = op_inst_q;
    op_rd_d       = op_rd_q;
    op_rd_we_d    = op_rd_we_q;
    op_is_load_d  = op_is_load_q;
    op_funct3_d   = op_funct3_q;
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_inst_d    = out_inst_q;
    out_rd_d      = out_rd_q;
    out_rd_we_d   = out_rd_we_q;
    out_wdata_d   = out_wdata_q;
    out_exc_d     = out_exc_q;
    if (issue_s) begin
      dreq_valid_d  = 1'b1;
      dreq_addr_d   = in_alu_result;
      dreq_write_d  = !in_is_load;
      dreq_strobe_d = in_is_load ? 8'h00 : store_strobe(in_funct3[1:0], in_alu_result[2:0]);
      dreq_data_d   = in_is_load ? 64'd0 : (in_store_data << {in_alu_result[2:0], 3'b000});
      op_pc_d       = in_pc;
      op_inst_d     = in_inst;
      op_rd_d       = in_rd;
      op_rd_we_d    = in_rd_we;
      op_is_load_d  = in_is_load;
      op_funct3_d   = in_funct3;
    end else if (done_s) begin
      dreq_valid_d  = 1'b0;
    end else begin
      dreq_valid_d  = dreq_valid_q;
    end
    // A completing result overrides the drain of the previous one.
    if (direct_s) begin
      out_valid_d = 1'b1;
      out_pc_d    = in_pc;
      out_inst_d  = in_inst;
      out_rd_d    = in_rd;
      out_rd_we_d = exc_s ? 1'b0 : in_rd_we;
      out_wdata_d = exc_s ? 64'd0 : in_alu_result;
      out_exc_d   = exc_s;
    end else if (done_s) begin
      out_valid_d = 1'b1;
      out_pc_d    = op_pc_q;
      out_inst_d  = op_inst_q;
      out_rd_d    = op_rd_q;
      out_rd_we_d = op_rd_we_q;
      out_wdata_d = op_is_load_q ? load_extract(op_funct3_q, dreq_addr_q[2:0], dresp_data) : 64'd0;
      out_exc_d   = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= 64'd0;
      dreq_write_q  <= 1'b0;
      dreq_strobe_q <= 8'h00;
      dreq_data_q   <= 64'd0;
      op_pc_q       <= 64'd0;
      op_inst_q     <= 32'd0;
      op_rd_q       <= 5'd0;
      op_rd_we_q    <= 1'b0;
      op_is_load_q  <= 1'b0;
      op_funct3_q   <= 3'd0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= 64'd0;
      out_inst_q    <= 32'd0;
      out_rd_q      <= 5'd0;
      out_rd_we_q   <= 1'b0;
      out_wdata_q   <= 64'd0;
      out_exc_q     <= 1'b0;
    end else begin
      dreq_valid_q  <= dreq_valid_d;
      dreq_addr_q   <= dreq_addr_d;
      dreq_write_q  <= dreq_write_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_data_q   <= dreq_data_d;
      op_pc_q       <= op_pc_d;
      op_inst_q     <= op_inst_d;
      op_rd_q       <= op_rd_d;
      op_rd_we_q    <= op_rd_we_d;
      op_is_load_q  <= op_is_load_d;
      op_funct3_q   <= op_funct3_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_inst_q    <= out_inst_d;
      out_rd_q      <= out_rd_d;
      out_rd_we_q   <= out_rd_we_d;
      out_wdata_q   <= out_wdata_d;
      out_exc_q     <= out_exc_d;
    end
  end

  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = dreq_addr_q;
  assign dreq_write  = dreq_write_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_data   = dreq_data_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_inst    = out_inst_q;
  assign out_rd      = out_rd_q;
  assign out_rd_we   = out_rd_we_q;
  assign out_wdata   = out_wdata_q;
  assign out_exc     = out_exc_q;

endmodule

// File: tb/tb_memory_access.sv
// Randomized and directed bench for memory_access against a transaction-level reference model.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_pc, in_alu_result, in_store_data;
  logic [31:0] in_inst;
  logic [2:0]  in_funct3;
  logic        in_is_load, in_is_store, in_rd_we;
  logic [4:0]  in_rd;
  logic        dreq_valid, dreq_write;
  logic [63:0] dreq_addr, dreq_data;
  logic [7:0]  dreq_strobe;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        out_valid, out_ready, out_rd_we, out_exc;
  logic [63:0] out_pc, out_wdata;
  logic [31:0] out_inst;
  logic [4:0]  out_rd;

  always #5 clk = ~clk;

  memory_access #(.XLEN(64), .MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_funct3(in_funct3), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_ok(dresp_ok),
    .dresp_data(dresp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_wdata(out_wdata), .out_exc(out_exc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one pending memory op and one pending result.
  bit          m_busy, m_out_valid, m_acc;
  logic [63:0] m_addr, m_sd, m_pc;
  logic [31:0] m_inst;
  logic [4:0]  m_rd;
  logic        m_we, m_ld;
  logic [2:0]  m_f3;
  int          m_wait;
  logic [63:0] e_pc, e_wdata;
  logic [31:0] e_inst;
  logic [4:0]  e_rd;
  logic        e_we, e_exc;
  bit          use_force;
  int          wait_force;
  logic [63:0] rdata_force;

  function automatic int unsigned ref_size(input logic [2:0] f3);
    return 32'd1 << f3[1:0];
  endfunction

  function automatic logic ref_exc(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [63:0] addr);
    logic bad;
    if (!ld && !st) return 1'b0;
    bad = ld ? (f3 == 3'b111) : f3[2];
    return bad || ((addr % 64'(ref_size(f3))) != 64'd0);
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr,
                                           input logic [63:0] data);
    int unsigned sz;
    logic [63:0] v, mask;
    sz = ref_size(f3);
    v = data >> (8 * (addr % 8));
    mask = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    v = v & mask;
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] ref_strobe(input logic [2:0] f3, input logic [63:0] addr);
    logic [15:0] s;
    s = ((16'd1 << ref_size(f3)) - 16'd1) << (addr % 8);
    return s[7:0];
  endfunction

  task automatic tick();
    logic exp_ready, acc, done, mem, exc;
    #1;
    exp_ready = !m_busy && (!m_out_valid || out_ready);
    check_eq("in_ready", in_ready, exp_ready);
    acc  = in_valid && exp_ready;
    done = m_busy && dresp_ok;
    mem  = in_is_load || in_is_store;
    exc  = ref_exc(in_is_load, in_is_store, in_funct3, in_alu_result);
    if (acc && (!mem || exc)) begin
      m_out_valid = 1'b1;
      e_pc = in_pc; e_inst = in_inst; e_rd = in_rd;
      e_we = exc ? 1'b0 : in_rd_we;
      e_wdata = exc ? 64'd0 : in_alu_result;
      e_exc = exc;
    end else if (done) begin
      m_out_valid = 1'b1;
      e_pc = m_pc; e_inst = m_inst; e_rd = m_rd; e_we = m_we; e_exc = 1'b0;
      e_wdata = m_ld ? ref_load(m_f3, m_addr, dresp_data) : 64'd0;
    end else if (m_out_valid && out_ready) begin
      m_out_valid = 1'b0;
    end
    if (acc && mem && !exc) begin
      m_busy = 1'b1;
      m_addr = in_alu_result; m_sd = in_store_data; m_pc = in_pc; m_inst = in_inst;
      m_rd = in_rd; m_we = in_rd_we; m_ld = in_is_load; m_f3 = in_funct3;
      m_wait = (wait_force > 0) ? wait_force : int'($urandom_range(1, 4));
    end else if (done) begin
      m_busy = 1'b0;
    end
    m_acc = acc;
    @(negedge clk);
    check_eq("out_valid", out_valid, m_out_valid);
    if (m_out_valid) begin
      check_eq("out_pc", out_pc, e_pc);
      check_eq("out_inst", out_inst, e_inst);
      check_eq("out_rd", out_rd, e_rd);
      check_eq("out_rd_we", out_rd_we, e_we);
      check_eq("out_wdata", out_wdata, e_wdata);
      check_eq("out_exc", out_exc, e_exc);
    end
    check_eq("dreq_valid", dreq_valid, m_busy);
    if (m_busy) begin
      check_eq("dreq_addr", dreq_addr, m_addr);
      check_eq("dreq_write", dreq_write, !m_ld);
      check_eq("dreq_strobe", dreq_strobe, m_ld ? 8'h00 : ref_strobe(m_f3, m_addr));
      if (!m_ld) check_eq("dreq_data", dreq_data, m_sd << (8 * (m_addr % 8)));
    end
  endtask

  task automatic bus_drive();
    dresp_ok = 1'b0;
    dresp_data = use_force ? rdata_force : {$urandom, $urandom};
    if (m_busy) begin
      if (m_wait <= 1) dresp_ok = 1'b1;
      else m_wait--;
    end else if (!use_force && $urandom_range(0, 9) == 0) begin
      dresp_ok = 1'b1;
    end
  endtask

  task automatic set_op(input logic [63:0] alu, input logic [63:0] sd, input logic [2:0] f3,
                        input logic ld, input logic st);
    in_pc = 64'h8000_0000 + alu; in_inst = 32'h0000_0013 ^ alu[31:0]; in_rd = 5'd5;
    in_rd_we = ld || !st; in_alu_result = alu; in_store_data = sd; in_funct3 = f3;
    in_is_load = ld; in_is_store = st;
  endtask

  task automatic gen_op();
    int kind;
    logic [2:0] amask;
    kind = int'($urandom_range(0, 19));
    in_pc = {$urandom, $urandom}; in_inst = $urandom; in_rd = 5'($urandom);
    in_rd_we = 1'($urandom); in_store_data = {$urandom, $urandom};
    in_funct3 = 3'($urandom); in_alu_result = {$urandom, $urandom};
    in_is_load = (kind >= 8 && kind < 15) || kind == 19;
    in_is_store = kind >= 15;
    amask = 3'b111 << in_funct3[1:0];
    if ($urandom_range(0, 3) != 0) in_alu_result[2:0] = in_alu_result[2:0] & amask;
    in_valid = 1'b1;
  endtask

  task automatic do_op(input string tag, input logic [63:0] alu, input logic [63:0] sd,
                       input logic [2:0] f3, input logic ld, input logic st, input int waits,
                       input logic [63:0] rdata, input logic [63:0] exp_wdata,
                       input logic exp_exc, input int exp_req, input logic [7:0] exp_strobe,
                       input logic [63:0] exp_sdata);
    int nreq;
    bit seen, first;
    nreq = 0; seen = 1'b0; first = 1'b1;
    set_op(alu, sd, f3, ld, st);
    in_valid = 1'b1; out_ready = 1'b1;
    use_force = 1'b1; wait_force = waits; rdata_force = rdata;
    for (int i = 0; i < 20 && !seen; i++) begin
      bus_drive();
      tick();
      if (m_acc) in_valid = 1'b0;
      if (dreq_valid) begin
        nreq++;
        if (first && st && !ld) begin
          check_eq({tag, "_strobe"}, dreq_strobe, exp_strobe);
          check_eq({tag, "_sdata"}, dreq_data, exp_sdata);
          check_eq({tag, "_write"}, dreq_write, 1'b1);
          first = 1'b0;
        end
      end
      if (m_out_valid) begin
        seen = 1'b1;
        check_eq({tag, "_wdata"}, out_wdata, exp_wdata);
        check_eq({tag, "_exc"}, out_exc, exp_exc);
      end
    end
    check_eq({tag, "_done"}, seen, 1'b1);
    check_eq({tag, "_nreq"}, nreq, exp_req);
    in_valid = 1'b0; use_force = 1'b0; wait_force = 0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dresp_ok = 1'b0; dresp_data = 64'd0;
    set_op(64'd0, 64'd0, 3'd0, 1'b0, 1'b0);
    m_busy = 1'b0; m_out_valid = 1'b0; m_wait = 0; use_force = 1'b0; wait_force = 0;
    rdata_force = 64'd0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_dreq_valid", dreq_valid, 1'b0);
    check_eq("rst_out_wdata", out_wdata, 64'd0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    do_op("alu", 64'h1234, 64'd0, 3'd0, 1'b0, 1'b0, 1, 64'd0, 64'h1234, 1'b0, 0, 8'h00, 64'd0);
    do_op("lb", 64'h1003, 64'd0, 3'b000, 1'b1, 1'b0, 3, 64'h0000_0000_8000_0000,
          64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 8'h00, 64'd0);
    do_op("lbu", 64'h1003, 64'd0, 3'b100, 1'b1, 1'b0, 3, 64'h0000_0000_8000_0000,
          64'h80, 1'b0, 3, 8'h00, 64'd0);
    do_op("sh", 64'h2006, 64'hABCD, 3'b001, 1'b0, 1'b1, 1, 64'd0, 64'd0, 1'b0, 1,
          8'hC0, 64'hABCD_0000_0000_0000);
    do_op("lw_mis", 64'h1002, 64'd0, 3'b010, 1'b1, 1'b0, 1, 64'd0, 64'd0, 1'b1, 0, 8'h00, 64'd0);
    do_op("ld_f7", 64'h1008, 64'd0, 3'b111, 1'b1, 1'b0, 1, 64'd0, 64'd0, 1'b1, 0, 8'h00, 64'd0);
    do_op("st_f4", 64'h1008, 64'h55, 3'b100, 1'b0, 1'b1, 1, 64'd0, 64'd0, 1'b1, 0, 8'h00, 64'd0);
    do_op("ldst", 64'h1010, 64'd0, 3'b011, 1'b1, 1'b1, 2, 64'h0123_4567_89AB_CDEF,
          64'h0123_4567_89AB_CDEF, 1'b0, 2, 8'h00, 64'd0);
    do_op("lh", 64'h1006, 64'd0, 3'b001, 1'b1, 1'b0, 1, 64'h8001_0000_0000_0000,
          64'hFFFF_FFFF_FFFF_8001, 1'b0, 1, 8'h00, 64'd0);

    // Back-to-back non-memory ops, one accepted per cycle.
    use_force = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_op(64'(i * 17), 64'd0, 3'd0, 1'b0, 1'b0);
      in_valid = 1'b1;
      bus_drive();
      tick();
      check_eq("b2b_wdata", out_wdata, 64'(i * 17));
    end
    in_valid = 1'b0;
    bus_drive(); tick();

    // Back-pressure from WB stalls the next instruction until the drain cycle.
    out_ready = 1'b0;
    set_op(64'hAAAA, 64'd0, 3'd0, 1'b0, 1'b0); in_valid = 1'b1;
    bus_drive(); tick();
    set_op(64'hBBBB, 64'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus_drive(); tick();
      check_eq("bp_hold", out_wdata, 64'hAAAA);
      check_eq("bp_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    bus_drive(); tick();
    check_eq("bp_next", out_wdata, 64'hBBBB);
    in_valid = 1'b0;
    bus_drive(); tick();

    // Reset while a load is in flight, then a stray response.
    wait_force = 4;
    set_op(64'h3000, 64'd0, 3'b011, 1'b1, 1'b0); in_valid = 1'b1;
    bus_drive(); tick();
    in_valid = 1'b0;
    bus_drive(); tick();
    check_eq("pre_rst_dreq", dreq_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_dreq_valid", dreq_valid, 1'b0);
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_in_ready", in_ready, 1'b1);
    m_busy = 1'b0; m_out_valid = 1'b0; m_wait = 0; wait_force = 0;
    @(negedge clk);
    rst_n = 1'b1; dresp_ok = 1'b1;
    tick();
    check_eq("stray_out_valid", out_valid, 1'b0);
    use_force = 1'b0;

    // Randomized traffic.
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!in_valid && $urandom_range(0, 9) < 7) gen_op();
      out_ready = ($urandom_range(0, 3) != 0);
      bus_drive();
      tick();
      if (m_acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_drive(); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
